// File: rtl/gcd_accel_peripheral.sv
// Memory-mapped subtractive-Euclid GCD accelerator with a relocatable 6-word register window.
// Define GCD_CYCLE_CNT_EN to implement the CYCLES counter register (offset 0x14).
module gcd_accel_peripheral #(
    parameter int unsigned DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_07D0
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        irq_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [2:0] RegOpa    = 3'd0;
    localparam logic [2:0] RegOpb    = 3'd1;
    localparam logic [2:0] RegCtrl   = 3'd2;
    localparam logic [2:0] RegStatus = 3'd3;
    localparam logic [2:0] RegResult = 3'd4;
    localparam logic [2:0] RegCycles = 3'd5;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              irq_en_q, irq_en_d;
    logic              done_q, done_d;
    logic              zero_err_q, zero_err_d;
    logic              irq_q, irq_d;
    logic [31:0]       cycles_rd;

    logic [29:0] word_off;
    logic        in_win;
    logic [2:0]  reg_sel;
    logic        wr_en;
    logic        wr_opa, wr_opb, wr_ctrl, wr_status;
    logic        busy;
    logic        start_go;
    logic        unused_bits;

    // Below-base addresses wrap to large offsets, so one compare bounds both ends.
    assign word_off  = data_addr_i[31:2] - BASE_ADDR[31:2];
    assign in_win    = (word_off < 30'd6);
    assign reg_sel   = word_off[2:0];
    assign wr_en     = data_we_i & in_win;
    assign wr_opa    = wr_en && (reg_sel == RegOpa);
    assign wr_opb    = wr_en && (reg_sel == RegOpb);
    assign wr_ctrl   = wr_en && (reg_sel == RegCtrl);
    assign wr_status = wr_en && (reg_sel == RegStatus);

    assign busy     = (state_q == StCalc);
    assign start_go = wr_ctrl && data_wdata_i[0] && (state_q == StIdle);

    assign unused_bits = ^{data_addr_i[1:0], data_wdata_i};

    always_comb begin
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        irq_en_d   = irq_en_q;
        done_d     = done_q;
        zero_err_d = zero_err_q;

        if (wr_opa && !busy) begin
            opa_d = data_wdata_i[DATA_W-1:0];
        end
        if (wr_opb && !busy) begin
            opb_d = data_wdata_i[DATA_W-1:0];
        end
        if (wr_ctrl) begin
            irq_en_d = data_wdata_i[1];
        end
        if (wr_status && data_wdata_i[1]) begin
            done_d = 1'b0;
        end
        if (wr_status && data_wdata_i[2]) begin
            zero_err_d = 1'b0;
        end

        // The FSM is evaluated after the W1C so a completing computation's set wins.
        case (state_q)
            StIdle: begin
                if (start_go) begin
                    a_d        = opa_q;
                    b_d        = opb_q;
                    done_d     = 1'b0;
                    zero_err_d = 1'b0;
                    state_d    = StCalc;
                end
            end
            StCalc: begin
                if ((a_q == '0) || (b_q == '0)) begin
                    result_d = a_q | b_q;
                    if ((a_q == '0) && (b_q == '0)) begin
                        zero_err_d = 1'b1;
                    end
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (a_q == b_q) begin
                    result_d = a_q;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end else if (a_q > b_q) begin
                    a_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign irq_d = done_q & irq_en_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            opa_q      <= '0;
            opb_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            zero_err_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            zero_err_q <= zero_err_d;
            irq_q      <= irq_d;
        end
    end

`ifdef GCD_CYCLE_CNT_EN
    logic [31:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q;
        if (start_go) begin
            cycles_d = '0;
        end else if (busy && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign cycles_rd = cycles_q;
`else
    assign cycles_rd = '0;
`endif

    always_comb begin
        data_rdata_o = '0;
        if (in_win) begin
            case (reg_sel)
                RegOpa:    data_rdata_o[DATA_W-1:0] = opa_q;
                RegOpb:    data_rdata_o[DATA_W-1:0] = opb_q;
                RegCtrl:   data_rdata_o[1] = irq_en_q;
                RegStatus: data_rdata_o[2:0] = {zero_err_q, done_q, busy};
                RegResult: data_rdata_o[DATA_W-1:0] = result_q;
                RegCycles: data_rdata_o = cycles_rd;
                default:   data_rdata_o = '0;
            endcase
        end
    end

    assign irq_o = irq_q;

endmodule

// File: tb/tb_gcd_accel_peripheral.sv
// Randomised bench for gcd_accel_peripheral: 32-bit instance checked every cycle against a
// schedule-level model, plus an 8-bit relocated instance checked with directed reads.
module tb_gcd_accel_peripheral;

    localparam logic [31:0] B32 = 32'h0000_07D0;
    localparam logic [31:0] B8  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata32, rdata8;
    logic        irq32, irq8;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    gcd_accel_peripheral #(.DATA_W(32), .BASE_ADDR(B32)) dut (
        .clk_i(clk), .reset_ni(reset_n), .data_addr_i(addr), .data_we_i(we),
        .data_wdata_i(wdata), .data_rdata_o(rdata32), .irq_o(irq32)
    );

    gcd_accel_peripheral #(.DATA_W(8), .BASE_ADDR(B8)) dut8 (
        .clk_i(clk), .reset_ni(reset_n), .data_addr_i(addr), .data_we_i(we),
        .data_wdata_i(wdata), .data_rdata_o(rdata8), .irq_o(irq8)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    function automatic int unsigned gcd_ref(int unsigned a, int unsigned b);
        int unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Subtraction count of the subtractive Euclid, via quotients, plus the final compare step.
    function automatic int unsigned kfun(int unsigned a, int unsigned b);
        int unsigned subs = 0;
        if (a == 0 || b == 0) return 1;
        while (a != b) begin
            if (a > b) begin
                if (a % b == 0) begin subs += a / b - 1; a = b; end
                else begin subs += a / b; a = a % b; end
            end else begin
                if (b % a == 0) begin subs += b / a - 1; b = a; end
                else begin subs += b / a; b = b % a; end
            end
        end
        return subs + 1;
    endfunction

    // Model: cyc counts edges; a computation started at edge m_s is busy for m_k cycles.
    int unsigned cyc = 0, m_s = 0, m_k = 0, m_idle_at = 0, m_cycles = 0;
    logic [31:0] m_opa = 0, m_opb = 0, m_result = 0, m_gcd = 0;
    bit m_irq_en = 0, m_done = 0, m_zero = 0, m_active = 0, m_irq = 0, m_zz = 0;

    always @(posedge clk) begin : model
        bit busy_old, idle_old, irq_nx;
        int unsigned off;
        cyc = cyc + 1;
        if (!reset_n) begin
            m_opa = 0; m_opb = 0; m_result = 0; m_cycles = 0;
            m_irq_en = 0; m_done = 0; m_zero = 0; m_active = 0; m_irq = 0;
            m_idle_at = cyc;
        end else begin
            busy_old = m_active;
            idle_old = !m_active && (cyc - 1 >= m_idle_at);
            irq_nx   = m_done && m_irq_en;
            if (we && addr >= B32 && addr - B32 < 32'd24) begin
                off = (addr - B32) >> 2;
                case (off)
                    0: if (!busy_old) m_opa = wdata;
                    1: if (!busy_old) m_opb = wdata;
                    2: begin
                        m_irq_en = wdata[1];
                        if (wdata[0] && idle_old) begin
                            m_s = cyc; m_k = kfun(m_opa, m_opb); m_gcd = gcd_ref(m_opa, m_opb);
                            m_zz = (m_opa == 0 && m_opb == 0);
                            m_done = 0; m_zero = 0; m_active = 1;
                        end
                    end
                    3: begin
                        if (wdata[1]) m_done = 0;
                        if (wdata[2]) m_zero = 0;
                    end
                    default: ;
                endcase
            end
            if (m_active && cyc == m_s + m_k) begin
                m_active = 0; m_done = 1; m_result = m_gcd; m_cycles = m_k;
                if (m_zz) m_zero = 1;
                m_idle_at = cyc + 1;
            end
            m_irq = irq_nx;
        end
    end

    function automatic logic [31:0] exp_rd(logic [31:0] a);
        logic [31:0] r;
        r = 0;
        if (a >= B32 && a - B32 < 32'd24) begin
            case ((a - B32) >> 2)
                0: r = m_opa;
                1: r = m_opb;
                2: r = {30'd0, m_irq_en, 1'b0};
                3: r = {29'd0, m_zero, m_done, m_active};
                4: r = m_result;
`ifdef GCD_CYCLE_CNT_EN
                5: r = m_active ? (cyc - m_s) : m_cycles;
`endif
                default: r = 0;
            endcase
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_rdata", rdata32, exp_rd(addr));
            chk("cyc_irq", {31'd0, irq32}, {31'd0, m_irq});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rd32(int unsigned off, logic [31:0] exp, string name);
        addr = B32 + 4 * off;
        @(negedge clk);
        chk(name, rdata32, exp);
        #1;
    endtask

    task automatic rd8(logic [31:0] a, logic [31:0] exp, string name);
        addr = a;
        @(negedge clk);
        chk(name, rdata8, exp);
        #1;
    endtask

    task automatic wait_done(bit wide, int unsigned budget);
        bit ok = 1'b0;
        addr = wide ? B32 + 12 : B8 + 12;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (wide ? rdata32[1] : rdata8[1]) begin ok = 1'b1; break; end
            tick();
        end
        chk(wide ? "done_wait32" : "done_wait8", {31'd0, ok}, 32'd1);
        tick();
    endtask

    task automatic run32(int unsigned a, int unsigned b, bit en);
        wr(B32, a);
        wr(B32 + 4, b);
        wr(B32 + 8, {30'd0, en, 1'b1});
        wait_done(1'b1, kfun(a, b) + 10);
    endtask

    task automatic run8(int unsigned a, int unsigned b);
        wr(B8, a);
        wr(B8 + 4, b);
        wr(B8 + 8, 32'd1);
        wait_done(1'b0, kfun(a, b) + 10);
    endtask

    initial begin
        int unsigned a, b;
        reset_n = 1'b0; we = 1'b0; addr = B32 + 12; wdata = 0;
        tick();
        chk_en = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) rd32(i, 32'd0, "reset_reg");
        chk("reset_irq", {31'd0, irq32}, 32'd0);

        // gcd(12,8): k=3, busy for three cycles, DONE next, irq one cycle later
        wr(B32, 12);
        wr(B32 + 4, 8);
        wr(B32 + 8, 3);
        addr = B32 + 12;
        @(negedge clk); chk("busy_c1", rdata32, 32'h1); tick();
        @(negedge clk); chk("busy_c2", rdata32, 32'h1); tick();
        @(negedge clk); chk("busy_c3", rdata32, 32'h1); tick();
        @(negedge clk); chk("done_c4", rdata32, 32'h2); chk("irq_c4", {31'd0, irq32}, 32'd0);
        tick();
        @(negedge clk); chk("irq_c5", {31'd0, irq32}, 32'd1);
        #1;
        rd32(4, 32'd4, "result_12_8");
`ifdef GCD_CYCLE_CNT_EN
        rd32(5, 32'd3, "cycles_12_8");
`endif
        wr(B32 + 12, 32'h2);
        tick();
        @(negedge clk); chk("irq_w1c", {31'd0, irq32}, 32'd0);
        #1;

        run32(0, 9, 1'b0);
        rd32(4, 32'd9, "result_0_9");
        rd32(3, 32'h2, "status_0_9");
`ifdef GCD_CYCLE_CNT_EN
        rd32(5, 32'd1, "cycles_0_9");
`endif
        run32(0, 0, 1'b0);
        rd32(4, 32'd0, "result_0_0");
        rd32(3, 32'h6, "status_0_0");

        // Writes during BUSY must not disturb the running computation
        wr(B32, 1000);
        wr(B32 + 4, 1);
        wr(B32 + 8, 32'h1);
        tick(); tick();
        wr(B32, 5);
        wr(B32 + 8, 32'h1);
        wait_done(1'b1, 1010);
        rd32(4, 32'd1, "result_busy");
`ifdef GCD_CYCLE_CNT_EN
        rd32(5, 32'd1000, "cycles_busy");
`endif
        rd32(0, 32'd1000, "opa_busy");

        // Reset mid-computation
        wr(B32, 1000);
        wr(B32 + 4, 1);
        wr(B32 + 8, 32'h3);
        repeat (10) tick();
        reset_n = 1'b0;
        tick(); tick();
        for (int i = 0; i < 6; i++) rd32(i, 32'd0, "midrst_reg");
        chk("midrst_irq", {31'd0, irq32}, 32'd0);
        reset_n = 1'b1;
        tick();
        run32(12, 8, 1'b1);
        rd32(4, 32'd4, "result_after_rst");

        for (int i = 0; i < 40; i++) begin
            a = $urandom_range(0, 400);
            b = $urandom_range(0, 400);
            if ($urandom_range(0, 7) == 0) a = 0;
            run32(a, b, 1'(($urandom_range(0, 1))));
            rd32(4, gcd_ref(a, b), "rand32_result");
            if ($urandom_range(0, 1) == 1) wr(B32 + 12, 32'h6);
            repeat ($urandom_range(0, 3)) tick();
        end

        // Narrow, relocated instance
        chk("irq8_idle", {31'd0, irq8}, 32'd0);
        wr(B8, 32'h1FF);
        rd8(B8, 32'hFF, "opa8_trunc");
        run8(255, 170);
        rd8(B8 + 16, 32'd85, "gcd8_255_170");
        rd8(32'hFC, 32'd0, "win8_below");
        rd8(32'h118, 32'd0, "win8_above");
        rd8(B8 + 4, 32'd170, "opb8");
        for (int i = 0; i < 10; i++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            run8(a, b);
            rd8(B8 + 16, gcd_ref(a, b), "rand8_result");
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gcd_accel_peripheral.md
# gcd_accel_peripheral

Memory-mapped GCD accelerator on the core data bus. Generalised, iterative successor of the fixed-width GCD peripheral, with operand width set by `DATA_W` and a relocatable register window. Software writes two operands and a start bit, then polls status or waits for `irq_o`. A subtractive Euclid engine runs over multiple cycles and leaves the result, status flags and an optional cycle count in registers.

## Interface
- `DATA_W`, default 32: operand/result width, 2..32; register fields zero-extended to 32 bits on read.
- `BASE_ADDR`, default 32'h0000_07D0: byte address of register 0; window is 6 words (0x00–0x17 offset).
- `clk_i` in 1: single clock; all state updates on rising edge.
- `reset_ni` in 1: reset is synchronous and active-low.
- `data_addr_i` in 32: byte address; word registers, `data_addr_i[1:0]` ignored.
- `data_we_i` in 1: write strobe; write takes effect at the rising edge where it is high and address is in the window.
- `data_wdata_i` in 32: write data.
- `data_rdata_o` out 32: combinational read data; 0 outside the window.
- `irq_o` out 1: registered level interrupt.

## Operation
- Register map (offset from `BASE_ADDR`):
  - 0x00 OPA: rw, `DATA_W` bits.
  - 0x04 OPB: rw, `DATA_W` bits.
  - 0x08 CTRL: bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN (rw).
  - 0x0C STATUS: bit0 BUSY (ro), bit1 DONE (write-1-to-clear), bit2 ZERO_ERR (write-1-to-clear).
  - 0x10 RESULT: ro.
  - 0x14 CYCLES: ro, 32-bit.
- Writes to OPA/OPB while BUSY are ignored. START while BUSY is ignored. Writes to read-only fields are ignored.
- FSM states:
  - IDLE: on START, load working regs a←OPA, b←OPB; clear DONE, ZERO_ERR and CYCLES; go to CALC.
  - CALC: one step per cycle, in priority order:
    - a==0 or b==0: result←a|b; ZERO_ERR←(a==0 && b==0); go to DONE.
    - a==b: result←a; go to DONE.
    - a>b: a←a−b.
    - else: b←b−a.
    - CYCLES increments every CALC cycle and saturates at 32'hFFFF_FFFF.
  - DONE: set DONE; go to IDLE (single cycle).
- BUSY=1 exactly while the state is CALC.
- `irq_o` = DONE & IRQ_EN, registered. Clearing DONE or IRQ_EN drops `irq_o` on the next cycle.
- A DONE W1C in the same cycle that the FSM sets DONE: the set wins.
- A START in the same cycle as a DONE W1C: START clears DONE anyway.
- RESULT and CYCLES hold their values until the next START.

## Timing
- Reset (`reset_ni`=0 at an edge): state IDLE; OPA, OPB, RESULT, CYCLES, CTRL and STATUS cleared.
  - Outputs: `irq_o`=0; `data_rdata_o` shows reset register values.
  - Reset mid-computation aborts the computation; no interrupt is raised.
- START written at edge N: BUSY=1 from N+1.
- A computation with k CALC cycles: BUSY falls and DONE=1 at N+1+k; `irq_o`=1 at N+2+k.
- k = number of subtractions + 1. Example: gcd(12,8) gives k=3.
- Any zero operand gives k=1.
- Worst case: gcd(2^DATA_W−1, 1) gives k=2^DATA_W−1.
- Reads are combinational from current register state; no wait states.

## Configuration
- `GCD_CYCLE_CNT_EN` defined: CYCLES counter and register are implemented as described.
- Not defined: no counter logic; offset 0x14 reads 0; all other behaviour unchanged.

## Test plan
- Reset: hold `reset_ni`=0 for 2 cycles mid-computation of gcd(1000,1).
  - Required: all registers read 0, `irq_o`=0, BUSY=0.
  - Required: a following gcd(12,8) works normally.
- Basic: OPA=12, OPB=8, IRQ_EN=1, START at edge N.
  - Required: BUSY at N+1..N+3; DONE at N+4; RESULT=4; CYCLES=3 (with `GCD_CYCLE_CNT_EN`); `irq_o`=1 at N+5.
  - Required: W1C of DONE drops `irq_o` next cycle.
- Zero operands:
  - (0,9): RESULT=9, ZERO_ERR=0, CYCLES=1.
  - (0,0): RESULT=0, ZERO_ERR=1.
- Busy protection: start gcd(1000,1), then write OPA=5 and START during BUSY.
  - Required: RESULT=1, CYCLES=1000, OPA reads 1000.
- Width/window: `DATA_W`=8, `BASE_ADDR`=32'h100, OPA written 32'h1FF.
  - Required: OPA reads 32'hFF.
  - Required: gcd(255,170)=85.
  - Required: reads at 0xFC and 0x118 return 0.
